// File: rtl/instr_encoder.sv
// instr_encoder: MIPS32 instruction encoder behind a 2-entry in-order skid buffer.
// Ports: clk, reset (sync, active-high); in_valid/in_ready with in_op, in_rs,
//   in_rt, in_rd, in_sa, in_imm, in_target; out_valid/out_ready with out_instr,
//   out_err; count = accepted requests since reset (wrapping).
package instr_encoder_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [6:0] {
        NOP,
        SLL, SRL, SRA, SLLV, SRLV, SRAV,
        JR, JALR, SYSCALL, BREAK,
        MFHI, MTHI, MFLO, MTLO,
        MULT, MULTU, DIV, DIVU,
        ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU,
        BLTZ, BGEZ, BLTZAL, BGEZAL,
        J, JAL,
        BEQ, BNE, BLEZ, BGTZ,
        ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI,
        LB, LH, LWL, LW, LBU, LHU, LWR,
        SB, SH, SWL, SW, SWR,
        MFC0, MTC0, ERET,
        MADD, MADDU, MUL, MSUB, MSUBU, CLZ, CLO,
        DECODE_ERROR
    } op_t;
endpackage

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  op_t                in_op,
    input  logic [4:0]         in_rs,
    input  logic [4:0]         in_rt,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_sa,
    input  logic [15:0]        in_imm,
    input  logic [25:0]        in_target,
    output logic               out_valid,
    input  logic               out_ready,
    output word_t              out_instr,
    output logic               out_err,
    output logic [COUNT_W-1:0] count
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic  err;
        word_t instr;
    } slot_t;

    localparam logic [4:0] Z5 = 5'd0;

    function automatic word_t r_fmt(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sa,
        input logic [5:0] fn
    );
        return {6'h00, rs, rt, rd, sa, fn};
    endfunction

    function automatic word_t i_fmt(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

    function automatic word_t s2_fmt(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [5:0] fn
    );
        return {6'h1C, rs, rt, rd, 5'h00, fn};
    endfunction

    slot_t  enc;
    state_t state, state_d;
    slot_t  head, head_d;
    slot_t  tail, tail_d;
    logic   accept, consume;

    // Fields an op does not name are never routed, so they encode as zero.
    always_comb begin
        enc = '0;
        unique case (in_op)
            NOP:     enc.instr = '0;
            SLL:     enc.instr = r_fmt(Z5, in_rt, in_rd, in_sa, 6'h00);
            SRL:     enc.instr = r_fmt(Z5, in_rt, in_rd, in_sa, 6'h02);
            SRA:     enc.instr = r_fmt(Z5, in_rt, in_rd, in_sa, 6'h03);
            SLLV:    enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h04);
            SRLV:    enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h06);
            SRAV:    enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h07);
            JR:      enc.instr = r_fmt(in_rs, Z5, Z5, Z5, 6'h08);
            JALR:    enc.instr = r_fmt(in_rs, Z5, in_rd, Z5, 6'h09);
            SYSCALL: enc.instr = r_fmt(Z5, Z5, Z5, Z5, 6'h0C);
            BREAK:   enc.instr = r_fmt(Z5, Z5, Z5, Z5, 6'h0D);
            MFHI:    enc.instr = r_fmt(Z5, Z5, in_rd, Z5, 6'h10);
            MTHI:    enc.instr = r_fmt(in_rs, Z5, Z5, Z5, 6'h11);
            MFLO:    enc.instr = r_fmt(Z5, Z5, in_rd, Z5, 6'h12);
            MTLO:    enc.instr = r_fmt(in_rs, Z5, Z5, Z5, 6'h13);
            MULT:    enc.instr = r_fmt(in_rs, in_rt, Z5, Z5, 6'h18);
            MULTU:   enc.instr = r_fmt(in_rs, in_rt, Z5, Z5, 6'h19);
            DIV:     enc.instr = r_fmt(in_rs, in_rt, Z5, Z5, 6'h1A);
            DIVU:    enc.instr = r_fmt(in_rs, in_rt, Z5, Z5, 6'h1B);
            ADD:     enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h20);
            ADDU:    enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h21);
            SUB:     enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h22);
            SUBU:    enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h23);
            AND:     enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h24);
            OR:      enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h25);
            XOR:     enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h26);
            NOR:     enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h27);
            SLT:     enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h2A);
            SLTU:    enc.instr = r_fmt(in_rs, in_rt, in_rd, Z5, 6'h2B);
            BLTZ:    enc.instr = i_fmt(6'h01, in_rs, 5'h00, in_imm);
            BGEZ:    enc.instr = i_fmt(6'h01, in_rs, 5'h01, in_imm);
            BLTZAL:  enc.instr = i_fmt(6'h01, in_rs, 5'h10, in_imm);
            BGEZAL:  enc.instr = i_fmt(6'h01, in_rs, 5'h11, in_imm);
            J:       enc.instr = {6'h02, in_target};
            JAL:     enc.instr = {6'h03, in_target};
            BEQ:     enc.instr = i_fmt(6'h04, in_rs, in_rt, in_imm);
            BNE:     enc.instr = i_fmt(6'h05, in_rs, in_rt, in_imm);
            BLEZ:    enc.instr = i_fmt(6'h06, in_rs, Z5, in_imm);
            BGTZ:    enc.instr = i_fmt(6'h07, in_rs, Z5, in_imm);
            ADDI:    enc.instr = i_fmt(6'h08, in_rs, in_rt, in_imm);
            ADDIU:   enc.instr = i_fmt(6'h09, in_rs, in_rt, in_imm);
            SLTI:    enc.instr = i_fmt(6'h0A, in_rs, in_rt, in_imm);
            SLTIU:   enc.instr = i_fmt(6'h0B, in_rs, in_rt, in_imm);
            ANDI:    enc.instr = i_fmt(6'h0C, in_rs, in_rt, in_imm);
            ORI:     enc.instr = i_fmt(6'h0D, in_rs, in_rt, in_imm);
            XORI:    enc.instr = i_fmt(6'h0E, in_rs, in_rt, in_imm);
            LUI:     enc.instr = i_fmt(6'h0F, Z5, in_rt, in_imm);
            LB:      enc.instr = i_fmt(6'h20, in_rs, in_rt, in_imm);
            LH:      enc.instr = i_fmt(6'h21, in_rs, in_rt, in_imm);
            LWL:     enc.instr = i_fmt(6'h22, in_rs, in_rt, in_imm);
            LW:      enc.instr = i_fmt(6'h23, in_rs, in_rt, in_imm);
            LBU:     enc.instr = i_fmt(6'h24, in_rs, in_rt, in_imm);
            LHU:     enc.instr = i_fmt(6'h25, in_rs, in_rt, in_imm);
            LWR:     enc.instr = i_fmt(6'h26, in_rs, in_rt, in_imm);
            SB:      enc.instr = i_fmt(6'h28, in_rs, in_rt, in_imm);
            SH:      enc.instr = i_fmt(6'h29, in_rs, in_rt, in_imm);
            SWL:     enc.instr = i_fmt(6'h2A, in_rs, in_rt, in_imm);
            SW:      enc.instr = i_fmt(6'h2B, in_rs, in_rt, in_imm);
            SWR:     enc.instr = i_fmt(6'h2E, in_rs, in_rt, in_imm);
            MFC0:    enc.instr = {6'h10, 5'h00, in_rt, in_rd, 11'h000};
            MTC0:    enc.instr = {6'h10, 5'h04, in_rt, in_rd, 11'h000};
            ERET:    enc.instr = 32'h4200_0018;
            MADD:    enc.instr = s2_fmt(in_rs, in_rt, in_rd, 6'h00);
            MADDU:   enc.instr = s2_fmt(in_rs, in_rt, in_rd, 6'h01);
            MUL:     enc.instr = s2_fmt(in_rs, in_rt, in_rd, 6'h02);
            MSUB:    enc.instr = s2_fmt(in_rs, in_rt, in_rd, 6'h04);
            MSUBU:   enc.instr = s2_fmt(in_rs, in_rt, in_rd, 6'h05);
            CLZ:     enc.instr = s2_fmt(in_rs, in_rt, in_rd, 6'h20);
            CLO:     enc.instr = s2_fmt(in_rs, in_rt, in_rd, 6'h21);
            default: enc.err = 1'b1;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign out_valid = (state != EMPTY);
    assign out_instr = head.instr;
    assign out_err   = head.err;

    // head is the word on out_*, tail the one queued behind it.
    always_comb begin
        state_d = state;
        head_d  = head;
        tail_d  = tail;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_d  = enc;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    head_d = enc;
                end else if (accept) begin
                    state_d = TWO;
                    tail_d  = enc;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    state_d = ONE;
                    head_d  = tail;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // in_ready is registered from the next state, so it never sees out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            head     <= '0;
            tail     <= '0;
            in_ready <= 1'b0;
            count    <= '0;
        end else begin
            state    <= state_d;
            head     <= head_d;
            tail     <= tail_d;
            in_ready <= (state_d != TWO);
            if (accept) begin
                count <= count + COUNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and round-trip scoreboard bench for instr_encoder.
// Stimulus pushes expectations; a negedge monitor pops and compares outputs.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int CW = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    op_t           in_op     = NOP;
    logic [4:0]    in_rs     = '0;
    logic [4:0]    in_rt     = '0;
    logic [4:0]    in_rd     = '0;
    logic [4:0]    in_sa     = '0;
    logic [15:0]   in_imm    = '0;
    logic [25:0]   in_target = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    word_t         out_instr;
    logic          out_err;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        bit    exact;
        bit    err;
        word_t word;
        op_t   op;
    } exp_t;

    exp_t          sb[$];
    exp_t          cur;
    logic [CW-1:0] exp_count = '0;

    bit    stall = 1'b0;
    word_t hold_w;
    logic  hold_e;

    instr_encoder #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_sa(in_sa), .in_imm(in_imm),
        .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Strict reference decoder: any field that must be zero but is not
    // decodes as DECODE_ERROR. z flags required-zero {rs,rt,rd,sa}.
    function automatic op_t dec(input word_t w);
        logic [5:0] opc;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] sa;
        logic [3:0] z;
        op_t r;
        opc = w[31:26]; rs = w[25:21]; rt = w[20:16];
        rd  = w[15:11]; sa = w[10:6];  fn = w[5:0];
        z = 4'b0000;
        r = DECODE_ERROR;
        case (opc)
            6'h00: begin
                case (fn)
                    6'h00: begin r = SLL;     z = 4'b1000; end
                    6'h02: begin r = SRL;     z = 4'b1000; end
                    6'h03: begin r = SRA;     z = 4'b1000; end
                    6'h04: begin r = SLLV;    z = 4'b0001; end
                    6'h06: begin r = SRLV;    z = 4'b0001; end
                    6'h07: begin r = SRAV;    z = 4'b0001; end
                    6'h08: begin r = JR;      z = 4'b0111; end
                    6'h09: begin r = JALR;    z = 4'b0101; end
                    6'h0C: begin r = SYSCALL; z = 4'b1111; end
                    6'h0D: begin r = BREAK;   z = 4'b1111; end
                    6'h10: begin r = MFHI;    z = 4'b1101; end
                    6'h11: begin r = MTHI;    z = 4'b0111; end
                    6'h12: begin r = MFLO;    z = 4'b1101; end
                    6'h13: begin r = MTLO;    z = 4'b0111; end
                    6'h18: begin r = MULT;    z = 4'b0011; end
                    6'h19: begin r = MULTU;   z = 4'b0011; end
                    6'h1A: begin r = DIV;     z = 4'b0011; end
                    6'h1B: begin r = DIVU;    z = 4'b0011; end
                    6'h20: begin r = ADD;     z = 4'b0001; end
                    6'h21: begin r = ADDU;    z = 4'b0001; end
                    6'h22: begin r = SUB;     z = 4'b0001; end
                    6'h23: begin r = SUBU;    z = 4'b0001; end
                    6'h24: begin r = AND;     z = 4'b0001; end
                    6'h25: begin r = OR;      z = 4'b0001; end
                    6'h26: begin r = XOR;     z = 4'b0001; end
                    6'h27: begin r = NOR;     z = 4'b0001; end
                    6'h2A: begin r = SLT;     z = 4'b0001; end
                    6'h2B: begin r = SLTU;    z = 4'b0001; end
                    default: r = DECODE_ERROR;
                endcase
                if (fn == 6'h00 && rd == 5'd0) begin
                    r = NOP;
                    z = 4'b0000;
                end
            end
            6'h01: begin
                case (rt)
                    5'h00: r = BLTZ;
                    5'h01: r = BGEZ;
                    5'h10: r = BLTZAL;
                    5'h11: r = BGEZAL;
                    default: r = DECODE_ERROR;
                endcase
            end
            6'h02: r = J;
            6'h03: r = JAL;
            6'h04: r = BEQ;
            6'h05: r = BNE;
            6'h06: begin r = BLEZ; z = 4'b0100; end
            6'h07: begin r = BGTZ; z = 4'b0100; end
            6'h08: r = ADDI;
            6'h09: r = ADDIU;
            6'h0A: r = SLTI;
            6'h0B: r = SLTIU;
            6'h0C: r = ANDI;
            6'h0D: r = ORI;
            6'h0E: r = XORI;
            6'h0F: begin r = LUI; z = 4'b1000; end
            6'h20: r = LB;
            6'h21: r = LH;
            6'h22: r = LWL;
            6'h23: r = LW;
            6'h24: r = LBU;
            6'h25: r = LHU;
            6'h26: r = LWR;
            6'h28: r = SB;
            6'h29: r = SH;
            6'h2A: r = SWL;
            6'h2B: r = SW;
            6'h2E: r = SWR;
            6'h10: begin
                if (w == 32'h4200_0018) r = ERET;
                else if (rs == 5'h00 && w[10:0] == 11'h0) r = MFC0;
                else if (rs == 5'h04 && w[10:0] == 11'h0) r = MTC0;
            end
            6'h1C: begin
                z = 4'b0001;
                case (fn)
                    6'h00: r = MADD;
                    6'h01: r = MADDU;
                    6'h02: r = MUL;
                    6'h04: r = MSUB;
                    6'h05: r = MSUBU;
                    6'h20: r = CLZ;
                    6'h21: r = CLO;
                    default: r = DECODE_ERROR;
                endcase
            end
            default: r = DECODE_ERROR;
        endcase
        if ((z & {|rs, |rt, |rd, |sa}) != 4'b0000) r = DECODE_ERROR;
        return r;
    endfunction

    // Expectation producer: a request seen here is accepted at the next edge.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            exp_count = '0;
        end else begin
            chk("count", 64'(count), 64'(exp_count));
            if (in_valid && in_ready) begin
                sb.push_back(cur);
                exp_count = exp_count + 1'b1;
            end
        end
    end

    // Monitor: a word seen valid and ready here is consumed at the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_stable", {31'h0, out_valid, out_err, out_instr},
                    {31'h0, 1'b1, hold_e, hold_w});
            end
            stall  = out_valid && !out_ready;
            hold_w = out_instr;
            hold_e = out_err;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%h required=none",
                             out_instr);
                end else begin
                    e = sb.pop_front();
                    if (e.exact) begin
                        chk({"word_", e.op.name()},
                            {31'h0, out_err, out_instr},
                            {31'h0, e.err, e.word});
                    end else begin
                        chk({"roundtrip_", e.op.name()},
                            {56'h0, out_err, dec(out_instr)},
                            {56'h0, 1'b0, e.op});
                    end
                end
            end
        end
    end

    task automatic drive(input op_t op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sa, input logic [15:0] imm,
                         input logic [25:0] tgt, input bit exact,
                         input word_t word, input bit err);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa;
        in_imm = imm; in_target = tgt;
        cur = '{exact, err, word, op};
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendx(input op_t op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sa, input logic [15:0] imm,
                         input logic [25:0] tgt, input word_t word);
        drive(op, rs, rt, rd, sa, imm, tgt, 1'b1, word, 1'b0);
        wait_accept();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drained", {63'h0, out_valid}, 64'h0);
    endtask

    initial begin
        op_t        o;
        logic [4:0] r5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
        chk("rst_out_instr", {32'h0, out_instr}, 64'h0);
        chk("rst_out_err", {63'h0, out_err}, 64'h0);
        chk("rst_count", 64'(count), 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_exit_ready", {63'h0, in_ready}, 64'h1);

        out_ready = 1'b1;
        sendx(ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1821);
        chk("latency_valid", {63'h0, out_valid}, 64'h1);
        chk("latency_word", {32'h0, out_instr}, 64'h0022_1821);
        sendx(LWR, 5'd4, 5'd5, 5'd17, 5'd9, 16'h0008, 26'h3FF_FFFF,
              32'h9885_0008);
        sendx(ERET, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              16'($urandom), 26'($urandom), 32'h4200_0018);
        sendx(MFC0, 5'd27, 5'd8, 5'd12, 5'd31, 16'hABCD, 26'h155_5555,
              32'h4008_6000);
        sendx(BGEZAL, 5'd3, 5'd7, 5'd9, 5'd1, 16'hFFFF, 26'h0,
              32'h0471_FFFF);
        drive(DECODE_ERROR, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h1,
              1'b1, 32'h0, 1'b1);
        wait_accept();
        drive(op_t'(7'd100), 5'd5, 5'd6, 5'd7, 5'd8, 16'h5678, 26'h2,
              1'b1, 32'h0, 1'b1);
        wait_accept();
        sendx(JR, 5'd31, 5'd5, 5'd6, 5'd7, 16'hFFFF, 26'h0, 32'h03E0_0008);
        sendx(JAL, 5'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h010_0000,
              32'h0C10_0000);
        sendx(SLL, 5'd9, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 32'h0002_1900);
        sendx(LUI, 5'd17, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3C01_1234);
        sendx(BLEZ, 5'd2, 5'd19, 5'd0, 5'd0, 16'h0010, 26'h0, 32'h1840_0010);
        sendx(SW, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0004, 26'h0, 32'hAFBF_0004);
        sendx(MUL, 5'd4, 5'd5, 5'd2, 5'd13, 16'h0, 26'h0, 32'h7085_1002);
        sendx(MTHI, 5'd7, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0, 32'h00E0_0011);
        sendx(NOP, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF,
              32'h0);
        wait_idle();

        out_ready = 1'b0;
        sendx(ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1821);
        sendx(SUBU, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 32'h0085_3023);
        drive(OR, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0, 1'b1,
              32'h00E8_4825, 1'b0);
        chk("third_blocked", {63'h0, in_ready}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("still_blocked", {63'h0, in_ready}, 64'h0);
        chk("head_held", {32'h0, out_instr}, 64'h0022_1821);
        out_ready = 1'b1;
        wait_accept();
        wait_idle();

        rand_ready = 1'b1;
        for (int k = 1; k < int'(DECODE_ERROR); k++) begin
            o  = op_t'(k);
            r5 = 5'($urandom_range(1, 31));
            drive(o, 5'($urandom), 5'($urandom), r5, 5'($urandom),
                  16'($urandom), 26'($urandom), 1'b0, 32'h0, 1'b0);
            wait_accept();
        end
        drive(SLL, 5'd0, 5'($urandom), 5'd0, 5'($urandom), 16'h0, 26'h0,
              1'b0, 32'h0, 1'b0);
        cur.op = NOP;
        wait_accept();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        wait_idle();

        out_ready = 1'b0;
        sendx(XOR, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 32'h0021_0826);
        sendx(AND, 5'd2, 5'd2, 5'd2, 5'd0, 16'h0, 26'h0, 32'h0042_1024);
        chk("two_full", {62'h0, out_valid, in_ready}, 64'h2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("midrst_count", 64'(count), 64'h0);
        chk("midrst_in_ready", {63'h0, in_ready}, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_exit_ready", {63'h0, in_ready}, 64'h1);
        chk("midrst_exit_valid", {63'h0, out_valid}, 64'h0);
        out_ready = 1'b1;
        sendx(ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1821);
        chk("post_rst_word", {32'h0, out_instr}, 64'h0022_1821);
        wait_idle();
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
